// File: rtl/pulse_monitor_pkg.sv
// Shared definitions for the pulse_monitor block.
// Holds the default channel count, counter widths, minimum legal step
// period and synchroniser depth, plus a channel status record used when
// passing a per-motor snapshot around at the default widths.
package pulse_monitor_pkg;

    localparam int unsigned N_MOTOR_DEF     = 6;
    localparam int unsigned POS_W_DEF       = 16;
    localparam int unsigned PER_W_DEF       = 15;
    localparam int unsigned MIN_PERIOD_DEF  = 100;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned SEL_W           = 3;

    typedef struct packed {
        logic [POS_W_DEF-1:0] pos;
        logic [PER_W_DEF-1:0] period;
        logic                 err;
    } chan_status_t;

endpackage

// File: rtl/pulse_monitor_if.sv
// Controller read port of pulse_monitor.
//   Sel      motor index to read
//   RdReq    single-cycle read strobe
//   RdAck    read data valid, one cycle after RdReq
//   RdPos    signed position snapshot
//   RdPeriod last measured step period
//   RdErr    sticky error flag of the selected motor
// master = controller side, slave = pulse_monitor side.
interface pulse_monitor_if
    import pulse_monitor_pkg::*;
#(
    parameter int unsigned POS_W = POS_W_DEF,
    parameter int unsigned PER_W = PER_W_DEF
);
    logic [SEL_W-1:0] Sel;
    logic             RdReq;
    logic             RdAck;
    logic [POS_W-1:0] RdPos;
    logic [PER_W-1:0] RdPeriod;
    logic             RdErr;

    modport master (
        output Sel, RdReq,
        input  RdAck, RdPos, RdPeriod, RdErr
    );

    modport slave (
        input  Sel, RdReq,
        output RdAck, RdPos, RdPeriod, RdErr
    );
endinterface

// File: rtl/pulse_monitor_channel.sv
// pulse_channel: one motor's receive-side checker.
// Synchronises the PU/MF/Dir pins, detects rising PU edges, keeps a
// wrapping signed position, a saturating age counter and the last measured
// step period, and raises a sticky error on an edge while disabled or on a
// step period shorter than MIN_PERIOD.
//   clk, rst   system clock, synchronous active-high reset
//   pu_i       step pulse pin (asynchronous)
//   mf_i       enable/busy pin (asynchronous)
//   dir_i      direction pin (asynchronous), 1 = +1 step
//   clear_i    synchronous clear of counters and error (level)
//   active_o   synchronised MF
//   pos_o      position counter
//   period_o   last measured period in clk cycles
//   err_o      sticky error flag
module pulse_channel
    import pulse_monitor_pkg::*;
#(
    parameter int unsigned POS_W       = POS_W_DEF,
    parameter int unsigned PER_W       = PER_W_DEF,
    parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pu_i,
    input  logic             mf_i,
    input  logic             dir_i,
    input  logic             clear_i,
    output logic             active_o,
    output logic [POS_W-1:0] pos_o,
    output logic [PER_W-1:0] period_o,
    output logic             err_o
);

    localparam logic [PER_W-1:0] PER_MAX = '1;
    localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);

    logic [SYNC_STAGES-1:0] pu_sync_q, mf_sync_q, dir_sync_q;
    logic                   pu_prev_q;
    logic                   pu_s, mf_s, dir_s, edge_s;

    logic [POS_W-1:0] pos_q, pos_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] age_q, age_d, age_inc;
    logic             err_q, err_d;
    logic             armed_q, armed_d;

    assign pu_s   = pu_sync_q[SYNC_STAGES-1];
    assign mf_s   = mf_sync_q[SYNC_STAGES-1];
    assign dir_s  = dir_sync_q[SYNC_STAGES-1];
    assign edge_s = pu_s & ~pu_prev_q;

    // Shift chains written as a truncating concat so a depth of 1 also works.
    always_ff @(posedge clk) begin
        if (rst) begin
            pu_sync_q  <= '0;
            mf_sync_q  <= '0;
            dir_sync_q <= '0;
            pu_prev_q  <= 1'b0;
        end else begin
            pu_sync_q  <= SYNC_STAGES'({pu_sync_q, pu_i});
            mf_sync_q  <= SYNC_STAGES'({mf_sync_q, mf_i});
            dir_sync_q <= SYNC_STAGES'({dir_sync_q, dir_i});
            pu_prev_q  <= pu_s;
        end
    end

    // age_inc doubles as "cycles since last edge": age counts from 0 right
    // after an edge, so the gap is age+1, held at PER_MAX once saturated.
    always_comb begin
        age_inc = (age_q == PER_MAX) ? PER_MAX : age_q + 1'b1;

        pos_d   = pos_q;
        per_d   = per_q;
        age_d   = age_inc;
        err_d   = err_q;
        armed_d = armed_q;

        if (clear_i) begin
            pos_d   = '0;
            per_d   = '0;
            age_d   = '0;
            err_d   = 1'b0;
            armed_d = 1'b0;
        end else if (edge_s) begin
            if (mf_s) begin
                pos_d = dir_s ? pos_q + 1'b1 : pos_q - 1'b1;
                if (armed_q) begin
                    per_d = age_inc;
                    if (age_inc < MIN_P) begin
                        err_d = 1'b1;
                    end
                end
                age_d   = '0;
                armed_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q   <= '0;
            per_q   <= '0;
            age_q   <= '0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            per_q   <= per_d;
            age_q   <= age_d;
            err_q   <= err_d;
            armed_q <= armed_d;
        end
    end

    assign active_o = mf_s;
    assign pos_o    = pos_q;
    assign period_o = per_q;
    assign err_o    = err_q;

endmodule

// File: rtl/pulse_monitor.sv
// pulse_monitor: receive-side checker for the stepper pulse/enable lines.
// Instantiates one pulse_channel per motor and serves per-motor snapshots
// over a request/acknowledge read port.
//   clk, rst  system clock, synchronous active-high reset
//   PUs       step pulse pins, one per motor
//   MFs       enable/busy pins, one per motor
//   Dir       direction pins, 1 = +1 step
//   Clear     per-motor synchronous clear (level)
//   Active    synchronised MFs
//   Err       sticky error flags of all motors
//   rd        controller read port (Sel/RdReq in, RdAck/RdPos/RdPeriod/RdErr out)
module pulse_monitor
    import pulse_monitor_pkg::*;
#(
    parameter int unsigned N_MOTOR     = N_MOTOR_DEF,
    parameter int unsigned POS_W       = POS_W_DEF,
    parameter int unsigned PER_W       = PER_W_DEF,
    parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_MOTOR-1:0] PUs,
    input  logic [N_MOTOR-1:0] MFs,
    input  logic [N_MOTOR-1:0] Dir,
    input  logic [N_MOTOR-1:0] Clear,
    output logic [N_MOTOR-1:0] Active,
    output logic [N_MOTOR-1:0] Err,
    pulse_monitor_if.slave     rd
);

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [PER_W-1:0] period;
        logic             err;
    } status_t;

    status_t status [N_MOTOR];

    for (genvar g = 0; g < N_MOTOR; g++) begin : g_ch
        pulse_channel #(
            .POS_W       (POS_W),
            .PER_W       (PER_W),
            .MIN_PERIOD  (MIN_PERIOD),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .pu_i     (PUs[g]),
            .mf_i     (MFs[g]),
            .dir_i    (Dir[g]),
            .clear_i  (Clear[g]),
            .active_o (Active[g]),
            .pos_o    (status[g].pos),
            .period_o (status[g].period),
            .err_o    (Err[g])
        );
        assign status[g].err = Err[g];
    end

    logic    ack_q, ack_d;
    status_t snap_q, snap_d;

    // An out-of-range Sel matches no channel, so it still acks with zero data.
    always_comb begin
        ack_d  = rd.RdReq;
        snap_d = '0;
        if (rd.RdReq) begin
            for (int unsigned i = 0; i < N_MOTOR; i++) begin
                if (rd.Sel == SEL_W'(i)) begin
                    snap_d = status[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q  <= 1'b0;
            snap_q <= '0;
        end else begin
            ack_q  <= ack_d;
            snap_q <= snap_d;
        end
    end

    assign rd.RdAck    = ack_q;
    assign rd.RdPos    = snap_q.pos;
    assign rd.RdPeriod = snap_q.period;
    assign rd.RdErr    = snap_q.err;

endmodule

// File: tb/tb_pulse_monitor.sv
module tb_pulse_monitor;
    import pulse_monitor_pkg::*;

    localparam int NM = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] PUs, MFs, Dir, Clear;
    logic [NM-1:0] Active, Err;

    pulse_monitor_if rd_if ();

    pulse_monitor dut (
        .clk    (clk),
        .rst    (rst),
        .PUs    (PUs),
        .MFs    (MFs),
        .Dir    (Dir),
        .Clear  (Clear),
        .Active (Active),
        .Err    (Err),
        .rd     (rd_if)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model: per-motor state derived from pulse time stamps.
    chan_status_t m_st [NM];
    bit           m_armed [NM];
    int unsigned  m_last [NM];

    typedef struct {
        int unsigned  due;
        chan_status_t v;
    } exp_t;
    exp_t q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NM; i++) begin
            m_st[i]    = '0;
            m_armed[i] = 1'b0;
            m_last[i]  = 0;
        end
    endfunction

    function automatic void model_clear(input int m);
        m_st[m]    = '0;
        m_armed[m] = 1'b0;
    endfunction

    function automatic void model_edge(input int m, input int unsigned stamp);
        int unsigned diff;
        if (MFs[m]) begin
            m_st[m].pos = Dir[m] ? m_st[m].pos + 16'd1 : m_st[m].pos - 16'd1;
            if (m_armed[m]) begin
                diff = stamp - m_last[m];
                m_st[m].period = (diff >= 32767) ? 15'h7FFF : 15'(diff);
                if (diff < 100) m_st[m].err = 1'b1;
            end
            m_last[m]  = stamp;
            m_armed[m] = 1'b1;
        end else begin
            m_st[m].err = 1'b1;
        end
    endfunction

    function automatic logic [NM-1:0] model_err();
        logic [NM-1:0] e;
        for (int i = 0; i < NM; i++) e[i] = m_st[i].err;
        return e;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic pulse(input int m, input int hi, input int lo);
        PUs[m] = 1'b1;
        model_edge(m, cyc);
        repeat (hi) @(negedge clk);
        PUs[m] = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic rd(input int s);
        exp_t e;
        e.due = cyc + 1;
        e.v   = (s < NM) ? m_st[s] : '0;
        q.push_back(e);
        rd_if.RdReq = 1'b1;
        rd_if.Sel   = 3'(s);
        @(negedge clk);
        rd_if.RdReq = 1'b0;
    endtask

    // Monitor: compares every ack against the scoreboard queue.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (rd_if.RdAck) begin
            if (q.size() == 0 || q[0].due != cyc) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 expected ack=0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("RdPos", 32'(rd_if.RdPos), 32'(e.v.pos));
                chk("RdPeriod", 32'(rd_if.RdPeriod), 32'(e.v.period));
                chk("RdErr", 32'(rd_if.RdErr), 32'(e.v.err));
            end
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                void'(q.pop_front());
                checks++;
                errors++;
                $display("FAIL missing_ack: got ack=0 expected ack=1 (cycle %0d)", cyc);
            end
            chk("idle_data", {rd_if.RdPos, rd_if.RdPeriod, rd_if.RdErr}, 32'h0);
        end
    end

    initial begin
        PUs = '0; MFs = '0; Dir = '0; Clear = '0;
        rd_if.RdReq = 1'b0; rd_if.Sel = '0;
        rst = 1'b1;
        model_reset();
        settle(3);
        chk("rst_Active", 32'(Active), 32'h0);
        chk("rst_Err", 32'(Err), 32'h0);
        chk("rst_RdAck", 32'(rd_if.RdAck), 32'h0);
        rst = 1'b0;
        settle(2);

        // Motor 0: ten forward steps at period 100.
        MFs[0] = 1'b1; Dir[0] = 1'b1;
        settle(4);
        repeat (10) pulse(0, 3, 97);
        rd(0);
        chk("Active0", 32'(Active[0]), 32'h1);

        // Motor 2: reverse steps below zero, then wrap past 0x7FFF.
        MFs[2] = 1'b1; Dir[2] = 1'b0;
        settle(4);
        repeat (3) pulse(2, 3, 10);
        rd(2);
        Clear[2] = 1'b1; model_clear(2);
        settle(1);
        Clear[2] = 1'b0; Dir[2] = 1'b1;
        settle(4);
        repeat (32767) pulse(2, 1, 1);
        settle(2);
        rd(2);
        pulse(2, 1, 3);
        rd(2);

        // Motor 0 idle through the long run: saturated period, no error.
        pulse(0, 3, 5);
        rd(0);

        // Motor 1: too-fast steps, then clear.
        MFs[1] = 1'b1; Dir[1] = 1'b1;
        settle(4);
        repeat (3) pulse(1, 3, 57);
        rd(1);
        chk("Err1_fast", 32'(Err[1]), 32'(m_st[1].err));
        Clear[1] = 1'b1; model_clear(1);
        settle(1);
        Clear[1] = 1'b0;
        settle(1);
        chk("Err1_clr", 32'(Err[1]), 32'(m_st[1].err));
        rd(1);
        pulse(1, 3, 5);
        rd(1);

        // Motor 3: step while disabled, then Active latency.
        pulse(3, 3, 5);
        chk("Err_vec_m3", 32'(Err), 32'(model_err()));
        rd(3);
        MFs[3] = 1'b1;
        @(posedge clk); #1;
        chk("Active3_d1", 32'(Active[3]), 32'h0);
        @(posedge clk); #1;
        chk("Active3_d2", 32'(Active[3]), 32'h1);
        @(negedge clk);

        // Motor 4: Clear coincident with the detected edge.
        MFs[4] = 1'b1; Dir[4] = 1'b1;
        settle(4);
        PUs[4] = 1'b1;
        repeat (2) @(negedge clk);
        Clear[4] = 1'b1; model_clear(4);
        @(negedge clk);
        Clear[4] = 1'b0; PUs[4] = 1'b0;
        settle(3);
        rd(4);
        rd(7);
        pulse(4, 3, 5);
        rd(4);

        // Motor 5: randomized direction/enable/gaps.
        for (int it = 0; it < 40; it++) begin
            MFs[5] = (($urandom % 6) != 0);
            Dir[5] = 1'($urandom % 2);
            settle(4);
            pulse(5, 3, int'($urandom_range(3, 200)));
            rd(5);
            if (($urandom % 3) == 0) rd(int'($urandom_range(0, 7)));
            chk("Err_vec_rand", 32'(Err), 32'(model_err()));
        end

        // Reset while a read is requested and a pulse is in flight.
        PUs[0] = 1'b1;
        rd_if.RdReq = 1'b1; rd_if.Sel = 3'd0;
        rst = 1'b1;
        @(negedge clk);
        rd_if.RdReq = 1'b0; PUs = '0;
        @(negedge clk);
        chk("midrst_RdAck", 32'(rd_if.RdAck), 32'h0);
        chk("midrst_Active", 32'(Active), 32'h0);
        chk("midrst_Err", 32'(Err), 32'h0);
        chk("midrst_data", {rd_if.RdPos, rd_if.RdPeriod, rd_if.RdErr}, 32'h0);
        model_reset();
        rst = 1'b0;
        settle(5);

        chk("pending_reads", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_monitor.md
Name: pulse_monitor

Overview:
Receive-side checker for the stepper pulse/enable lines driven toward the motor drivers. It samples the six PUs/MFs pairs and the direction lines, counts qualified step pulses into per-motor signed position counters, and measures the pulse period. It flags protocol violations and serves snapshots to the controller over a request/acknowledge read port. It sits on the driver-side pins, in loopback with the pulse generator, for closed-loop bring-up and fault detection.

Parameters:
N_MOTOR, 6, number of motor channels (Sel decode range 0..N_MOTOR-1)
POS_W, 16, width of signed position counter
PER_W, 15, width of period measurement, saturating
MIN_PERIOD, 100, minimum legal clk cycles between consecutive rising PU edges
SYNC_STAGES, 2, input synchroniser depth

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
PUs  in  N_MOTOR  step pulse lines, asynchronous to clk
MFs  in  N_MOTOR  per-motor enable/busy lines, asynchronous to clk
Dir  in  N_MOTOR  direction per motor: 1 = +1 step, 0 = -1 step
Clear  in  N_MOTOR  per-motor synchronous clear, level
Sel  in  3  motor index for read
RdReq  in  1  read request, single-cycle strobe
RdAck  out  1  read data valid, one cycle
RdPos  out  POS_W  position snapshot of the selected motor
RdPeriod  out  PER_W  last measured period of the selected motor
RdErr  out  1  sticky error flag of the selected motor
Active  out  N_MOTOR  synchronised MFs
Err  out  N_MOTOR  sticky error flags, all motors

Behaviour:
- Reset (rst=1 at a clk edge): all outputs are 0. All position, period, age and sticky flags are 0. The synchroniser flops are 0 and the seen-first-edge flags are 0.
- Each PUs/MFs/Dir bit passes through SYNC_STAGES flops. Rising-edge detect compares the synced value against the previous synced value. Latency from pin transition to position update is SYNC_STAGES+1 clk.
- Edge while synced MF=1: pos <= pos ± 1, per Dir sampled through the same synchroniser depth. Arithmetic is two's complement and wraps: 0x7FFF+1 gives 0x8000, and 0x0000-1 gives 0xFFFF.
- Edge while synced MF=0: position is unchanged and Err[i] is set.
- Period: a per-motor age counter increments every clk and saturates at 2^PER_W-1. On a qualified edge:
  - If the first-edge flag is set, period <= age+1 (clk cycles between edges). Then if age+1 < MIN_PERIOD, Err[i] is set.
  - age <= 0 and the first-edge flag is set.
  - The first edge after reset/Clear only arms the measurement: no period is recorded and there is no error check.
- Saturated age gives period = max; this is not an error.
- Clear[i]=1: pos, period, age, Err[i] and the first-edge flag are zeroed. Clear wins over a simultaneous edge, and that edge is discarded. Clear does not affect other motors or the synchronisers.
- Read: RdReq=1 in cycle T, with Sel captured in T. In T+1, RdAck=1 for one cycle and RdPos/RdPeriod/RdErr show the values as of the end of T.
  - Back-to-back RdReq is accepted every cycle, giving one ack per request.
  - When RdAck=0, the Rd* data outputs are 0.
  - Sel >= N_MOTOR gives RdAck=1 with all data 0.
- Active = synced MFs, with no further delay.
- rst mid-operation behaves like reset: a pending ack is dropped.

Decomposition:
- Shared package: N_MOTOR, POS_W, PER_W and MIN_PERIOD defaults, plus a channel status struct (pos, period, err).
- One natural sub-module, pulse_channel: synchroniser, edge detect, position, age and error for one motor. It is instantiated N_MOTOR times.
- The top level holds only the read mux/handshake.

Test Plan:
- MF0=1, Dir0=1, 10 PU0 pulses at period 100 clk, then RdReq with Sel=0 → RdAck one cycle later, RdPos=10, RdPeriod=100, RdErr=0.
- MF2=1, Dir2=0, 3 pulses from pos=0 → RdPos=0xFFFD. Continuing: preload via 0x7FFF pulses with Dir=1, then one more → 0x8000 wrap.
- MF1=1, pulses at period 60 → RdPeriod=60 and Err[1]=1 after the second edge. Clear[1] for 1 cycle → Err[1]=0, pos=0, and the next single pulse leaves period=0.
- MF3=0 with one PU3 pulse → pos unchanged, Err[3]=1. Active[3] follows MF3 with SYNC_STAGES cycles of delay.
- Clear[4] asserted in the same cycle as a detected edge → pos stays 0. RdReq on consecutive cycles with Sel=4, then Sel=7 → two acks, the second with all data 0.
- rst asserted while RdReq is pending and pulses are in flight → no RdAck next cycle, and all outputs are 0.
